// File: rtl/sdc_dsc_if.sv
// sdc_dsc_if: stream-in / binary-out bundle for the stochastic-to-digital converter.
// The master drives the stream side; the slave (sdc_dsc) returns the result.
interface sdc_dsc_if #(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1
);
  logic              en;
  logic              start;
  logic              sn_valid;
  logic [STRIDE-1:0] sn_in;
  logic [WIDTH-1:0]  bin_out;
  logic              done;
  logic              busy;
  logic              sat;

  modport master (
    output en,
    output start,
    output sn_valid,
    output sn_in,
    input  bin_out,
    input  done,
    input  busy,
    input  sat
  );

  modport slave (
    input  en,
    input  start,
    input  sn_valid,
    input  sn_in,
    output bin_out,
    output done,
    output busy,
    output sat
  );
endinterface

// File: rtl/sdc_dsc.sv
// sdc_dsc: counts ones over a 2^WIDTH-bit stochastic window, STRIDE bits per beat.
// Define SDC_CONTINUOUS_EN for free-running windows with no DONE gap cycle.
module sdc_dsc #(
  parameter int WIDTH  = 4,
  parameter int STRIDE = 1
) (
  input logic      clk,
  input logic      rst,
  sdc_dsc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam int PW = $clog2(STRIDE + 1);
  localparam logic [WIDTH-1:0] LAST =
    WIDTH'((1 << WIDTH) - STRIDE);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(STRIDE);
  localparam logic [WIDTH-1:0] MAXV = '1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] beat;
  logic [WIDTH-1:0] beat_nxt;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             sat_q;
  logic             sat_nxt;
  logic [PW-1:0]    pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < STRIDE; i++) begin
      pop = pop + PW'(bus.sn_in[i]);
    end
  end

  assign acc_sum = acc + (WIDTH + 1)'(pop);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    beat_nxt  = beat;
    bin_nxt   = bin_q;
    sat_nxt   = sat_q;
    done_nxt  = 1'b0;
    if (bus.en) begin
      case (state)
        IDLE: begin
          acc_nxt  = '0;
          beat_nxt = '0;
          if (bus.start) begin
            state_nxt = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.sn_valid) begin
            acc_nxt  = acc_sum;
            beat_nxt = beat + STEP;
            if (beat == LAST) begin
              // a full window is exactly 2^WIDTH ones: clamp
              done_nxt = 1'b1;
              sat_nxt  = acc_sum[WIDTH];
              bin_nxt  = acc_sum[WIDTH] ? MAXV
                                        : acc_sum[WIDTH-1:0];
`ifdef SDC_CONTINUOUS_EN
              acc_nxt  = '0;
              beat_nxt = '0;
`else
              state_nxt = DONE;
`endif
            end
          end
        end
        DONE: begin
          acc_nxt   = '0;
          beat_nxt  = '0;
          state_nxt = bus.start ? ACCUM : IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      beat   <= '0;
      bin_q  <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      beat   <= beat_nxt;
      bin_q  <= bin_nxt;
      done_q <= done_nxt;
      sat_q  <= sat_nxt;
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.done    = done_q;
  assign bus.sat     = sat_q;
  assign bus.busy    = (state == ACCUM);

endmodule

// File: tb/tb_sdc_dsc.sv
// tb_sdc_dsc: scoreboard bench, three converters (STRIDE 1/2/4) at WIDTH=4.
// Results are queued at stimulus time and popped on each done pulse.
module tb_sdc_dsc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdc_dsc_if #(.WIDTH(4), .STRIDE(1)) b1();
  sdc_dsc_if #(.WIDTH(4), .STRIDE(2)) b2();
  sdc_dsc_if #(.WIDTH(4), .STRIDE(4)) b4();

  sdc_dsc #(.WIDTH(4), .STRIDE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  sdc_dsc #(.WIDTH(4), .STRIDE(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  sdc_dsc #(.WIDTH(4), .STRIDE(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  int checks = 0;
  int errors = 0;
  int q1[$];
  int q2[$];
  int q4[$];
  int dn1 = 0;
  int dn2 = 0;
  int dn4 = 0;
  int bz1 = 0;
  int cyc = 0;
  int last1 = -1;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counter SNG with bit-reversed counter: exactly k ones per 16
  function automatic bit sng(int k, int i);
    logic [3:0] v;
    logic [3:0] r;
    v = i[3:0];
    r = {v[0], v[1], v[2], v[3]};
    return int'(r) < k;
  endfunction

  function automatic int expv(int k);
    return (k >= 16) ? 31 : k;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b1.busy) bz1++;
    if (b1.done) begin
      dn1++;
`ifdef SDC_CONTINUOUS_EN
      if (last1 >= 0) check("gap1", cyc - last1, 16);
      last1 = cyc;
`endif
      if (q1.size() == 0) check("spur1", 1, 0);
      else check("res1", int'({b1.sat, b1.bin_out}), q1.pop_front());
    end
    if (b2.done) begin
      dn2++;
      if (q2.size() == 0) check("spur2", 1, 0);
      else check("res2", int'({b2.sat, b2.bin_out}), q2.pop_front());
    end
    if (b4.done) begin
      dn4++;
      if (q4.size() == 0) check("spur4", 1, 0);
      else check("res4", int'({b4.sat, b4.bin_out}), q4.pop_front());
    end
  end

  task automatic win1(int k, bit skip_start, int mid);
    if (!skip_start) begin
      b1.start = 1'b1;
      tick();
      b1.start = 1'b0;
    end
    q1.push_back(expv(k));
    for (int i = 0; i < 16; i++) begin
      b1.sn_valid = 1'b1;
      b1.sn_in[0] = sng(k, i);
      b1.start    = (i == mid);
      tick();
    end
    b1.start    = 1'b0;
    b1.sn_valid = 1'b0;
  endtask

  task automatic idle_all();
    b1.en = 1'b0; b1.start = 1'b0; b1.sn_valid = 1'b0; b1.sn_in = '0;
    b2.en = 1'b0; b2.start = 1'b0; b2.sn_valid = 1'b0; b2.sn_in = '0;
    b4.en = 1'b0; b4.start = 1'b0; b4.sn_valid = 1'b0; b4.sn_in = '0;
  endtask

  initial begin
    idle_all();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_bin", int'(b1.bin_out), 0);
    check("rst_done", int'(b1.done), 0);
    check("rst_busy", int'(b1.busy), 0);
    check("rst_sat", int'(b1.sat), 0);
    rst = 1'b1;
    tick();
    b1.en = 1'b1;
    b2.en = 1'b1;
    b4.en = 1'b1;

`ifdef SDC_CONTINUOUS_EN
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      int k;
      k = (w < 2) ? 9 : 3;
      check("c_busy", int'(b1.busy), 1);
      q1.push_back(k);
      for (int i = 0; i < 16; i++) begin
        b1.sn_valid = 1'b1;
        b1.sn_in[0] = sng(k, i);
        tick();
      end
    end
    b1.sn_valid = 1'b0;
    check("c_busy_end", int'(b1.busy), 1);
    repeat (3) tick();
    check("c_ndone", dn1, 4);
`else
    // basic window, busy width and done latency
    bz1 = 0;
    win1(5, 1'b0, -1);
    check("t1_done", int'(b1.done), 1);
    check("t1_busy_done", int'(b1.busy), 0);
    tick();
    check("t1_busy_cnt", bz1, 16);
    check("t1_pulse", int'(b1.done), 0);
    tick();

    // saturation then clear
    win1(16, 1'b0, -1);
    tick();
    check("t2_sat_hold", int'(b1.sat), 1);
    win1(0, 1'b0, -1);
    repeat (2) tick();

    // mid-window start ignored, start held in DONE
    win1(6, 1'b0, 7);
    check("t5_done", int'(b1.done), 1);
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    check("t5_no_idle", int'(b1.busy), 1);
    win1(11, 1'b1, -1);
    repeat (2) tick();
    check("t5_ndone", dn1, 5);

    // STRIDE=4 with bubbles and an en stall
    q4.push_back(12);
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      repeat ($urandom_range(0, 3)) begin
        b4.sn_valid = 1'b0;
        b4.sn_in    = 4'b1111;
        tick();
      end
      b4.sn_valid = 1'b1;
      b4.sn_in    = 4'b0111;
      if (j == 2) begin
        b4.en    = 1'b0;
        b4.start = 1'b1;
        repeat (5) tick();
        check("t3_stall_busy", int'(b4.busy), 1);
        b4.en    = 1'b1;
        b4.start = 1'b0;
      end
      tick();
    end
    check("t3_done", int'(b4.done), 1);
    b4.sn_valid = 1'b0;
    repeat (3) tick();
    check("t3_ndone", dn4, 1);

    // STRIDE=2 reset mid-window
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int j = 0; j < 5; j++) begin
      b2.sn_valid = 1'b1;
      b2.sn_in    = 2'b01;
      tick();
    end
    b2.sn_valid = 1'b0;
    rst = 1'b0;
    #2;
    check("t4_rst_busy", int'(b2.busy), 0);
    check("t4_rst_bin1", int'(b1.bin_out), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("t4_idle", int'(b2.busy), 0);
    q2.push_back(8);
    b2.start = 1'b1;
    tick();
    b2.start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      b2.sn_valid = 1'b1;
      b2.sn_in    = 2'b01;
      tick();
    end
    b2.sn_valid = 1'b0;
    repeat (3) tick();
    check("t4_ndone", dn2, 1);
    check("t4_bin", int'(b2.bin_out), 8);
`endif

    check("q1_left", q1.size(), 0);
    check("q2_left", q2.size(), 0);
    check("q4_left", q4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdc_dsc.md
# sdc_dsc

Stochastic-to-digital converter: the receive end of the deterministic stochastic-computing datapath. It consumes a unary/stochastic bitstream of 2^WIDTH bits, STRIDE bits per beat, as produced by the counter-based SNG or by any DSC arithmetic stage. It counts the ones over one full window and returns the WIDTH-bit binary value. It sits at the output of every DSC compute lane, closing the binary → stream → binary loop.

## Interface
- WIDTH, 4: binary precision. Window length is 2^WIDTH bits. Legal range 2..16.
- STRIDE, 1: stream bits per beat. Legal values 1, 2, 4. Must be < 2^WIDTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  global enable. When low, all state holds and `start`/`sn_valid` are ignored.
- start  in  1  begin a new conversion window (one-cycle request).
- sn_valid  in  1  `sn_in` carries a valid beat this cycle.
- sn_in  in  STRIDE  stream bits for this beat. Bit 0 is the earliest in stream order.
- bin_out  out  WIDTH  converted value. Registered; holds until the next `done`.
- done  out  1  one-cycle pulse: `bin_out`/`sat` updated this cycle.
- busy  out  1  high while a window is being accumulated.
- sat  out  1  the last window contained 2^WIDTH ones and was clamped.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- IDLE:
  - `en & start` → ACCUM.
  - Clears the accumulator (acc, WIDTH+1 bits) and the beat counter (beat, WIDTH bits).
- ACCUM:
  - Each cycle with `en & sn_valid`: acc += popcount(`sn_in`) and beat += STRIDE (mod 2^WIDTH).
  - The last beat is the accepted beat with beat == 2^WIDTH − STRIDE. It is added, then the FSM goes to DONE.
  - Cycles without `sn_valid` are bubbles: no state change, no limit on their number.
  - `start` is ignored in ACCUM.
- DONE:
  - `done` = 1.
  - `bin_out` = acc[WIDTH-1:0] when acc < 2^WIDTH; otherwise `bin_out` = 2^WIDTH−1 and `sat` = 1. `sat` is cleared on every non-saturating `done`.
  - Next state: ACCUM if `en & start` (back-to-back windows, accumulator and beat counter cleared); else IDLE.
  - Beats presented in DONE or IDLE are dropped.
- `busy` = 1 in ACCUM, 0 in IDLE and DONE.
- Arithmetic:
  - Popcount is at most 4, so acc never exceeds 2^WIDTH and needs no wrap logic.
  - An SNG input of k (k < 2^WIDTH) produces exactly k ones per window, so `bin_out` equals k exactly.
- Reset mid-window: the window is aborted and no `done` is issued. After reset: `bin_out`=0, `done`=0, `busy`=0, `sat`=0, state IDLE.
- `en` low mid-window freezes acc, beat and state. The window resumes when `en` returns high.

## Timing
- `done` and the new `bin_out`/`sat` appear exactly 1 cycle after the last-beat edge.
- Minimum window length: 2^WIDTH/STRIDE accepted beats. Minimum start-to-done: 1 + 2^WIDTH/STRIDE cycles.
- Back-to-back throughput (start held in DONE): one window per 2^WIDTH/STRIDE + 1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SDC_CONTINUOUS_EN` defined:
  - Free-running mode; `start` is only needed once, from IDLE.
  - On the last beat, the FSM stays in ACCUM with acc and beat reloaded to zero, and the `done`/`bin_out`/`sat` update happens that same cycle, registered (same 1-cycle latency).
  - The next window's first beat is accepted the cycle after the last beat. No gap; DONE is unreachable.
  - `busy` stays high.
  - Cleanup of the FSM state back to IDLE happens only via reset.
- Not defined: the windowed behaviour described above. One `done` per `start`, with the DONE gap cycle.

## Test plan
- WIDTH=4, STRIDE=1. Start, then 16 beats from the counter SNG with bin_in=5 → `done` 1 cycle after beat 16, `bin_out`=5, `sat`=0, `busy` high for exactly 16 cycles.
- WIDTH=4, STRIDE=1. 16 beats of `sn_in`=1 → `bin_out`=15, `sat`=1. Then a window of all zeros → `bin_out`=0, `sat`=0.
- WIDTH=4, STRIDE=4. 4 beats of 4'b0111 with random `sn_valid` bubbles (up to 3 cycles) and one 5-cycle `en`-low stall → `bin_out`=12, exactly one `done`.
- WIDTH=4, STRIDE=2. Assert `rst` low after 5 beats, release, start a fresh window of 8 beats of 2'b01 → no `done` for the aborted window; final `bin_out`=8.
- WIDTH=4, STRIDE=1. `start` pulsed mid-window, and `start` held in the DONE cycle → the mid-window pulse is ignored; the second window begins with no IDLE cycle and produces its own correct value.
- With `SDC_CONTINUOUS_EN`, WIDTH=4, STRIDE=1, continuous SNG stream with bin_in=9, then 3 → `done` every 16 cycles with no gap; `bin_out`=9, then 3 from the first full window after the switch.
